// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 scan-out of a 320x240 RGB565 frame buffer at 2x scale.
// Three-stage pipeline: counters -> RAM address -> RAM data -> registered pins.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BUF_W    = 320,
    parameter int BUF_H    = 240,
    parameter int AW       = 17,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] addr_out,
    output logic          regread,
    input  logic [DW-1:0] data_out,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic [4:0]    vga_r,
    output logic [5:0]    vga_g,
    output logic [4:0]    vga_b,
    output logic          vblank,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [AW-1:0] ROW_STEP      = AW'(BUF_W);
    localparam logic [AW-1:0] LAST_ROW_BASE = AW'((BUF_H - 1) * BUF_W);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [AW-1:0] row_base;

    logic active;
    logic hs_c;
    logic vs_c;
    logic vb_c;
    logic fe_c;

    logic act1, hs1, vs1, vb1, fe1;
    logic act2, hs2, vs2, vb2, fe2;

    assign active = (h < H_ACT) && (v < V_ACT);
    assign hs_c   = !((h >= HS_BEGIN) && (h <= HS_END));
    assign vs_c   = !((v >= VS_BEGIN) && (v <= VS_END));
    assign vb_c   = (v >= V_ACT);
    assign fe_c   = (h == '0) && (v == V_ACT);

    // row_base tracks (v>>1)*BUF_W incrementally; it advances after each odd
    // line and is capped at the last buffer row so no address can overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h        <= '0;
            v        <= '0;
            row_base <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
                v        <= '0;
                row_base <= '0;
            end else begin
                v <= v + 1'b1;
                if (v[0] && (row_base != LAST_ROW_BASE)) begin
                    row_base <= row_base + ROW_STEP;
                end
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out  <= '0;
            regread   <= 1'b0;
            act1      <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            vb1       <= 1'b0;
            fe1       <= 1'b0;
            act2      <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
            vb2       <= 1'b0;
            fe2       <= 1'b0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vblank    <= 1'b0;
            frame_end <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            regread <= active;
            if (active) begin
                addr_out <= row_base + AW'(h >> 1);
            end
            act1 <= active;
            hs1  <= hs_c;
            vs1  <= vs_c;
            vb1  <= vb_c;
            fe1  <= fe_c;

            act2 <= act1;
            hs2  <= hs1;
            vs2  <= vs1;
            vb2  <= vb1;
            fe2  <= fe1;

            // Colour is gated by the delayed active flag so blanking is black
            // whatever the RAM port happens to be returning.
            vga_hsync <= hs2;
            vga_vsync <= vs2;
            vblank    <= vb2;
            frame_end <= fe2;
            vga_r     <= act2 ? data_out[15:11] : 5'd0;
            vga_g     <= act2 ? data_out[10:5]  : 6'd0;
            vga_b     <= act2 ? data_out[4:0]   : 5'd0;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size instance for line/pixel behaviour and a
// short-frame instance (6 visible lines) for vsync, vblank and frame_end.
module tb_vga_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] a_addr, b_addr;
    logic        a_rr, b_rr;
    logic [15:0] a_data, b_data;
    logic        a_hs, a_vs, b_hs, b_vs;
    logic [4:0]  a_r, a_b, b_r, b_b;
    logic [5:0]  a_g, b_g;
    logic        a_vb, b_vb, a_fe, b_fe;

    logic [15:0] mem [0:76799];

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;
    int phase    = 0;
    int last_addr [2];
    int err [2][7];
    string sig_names [7] = '{"addr", "regread", "rgb", "hsync", "vsync", "vblank", "frame_end"};

    int fe_cnt = 0, fe_k1 = 0, fe_k2 = 0;
    int vs_low = 0, hs_low = 0, hs_first = 0;
    int b_max = 0;
    logic b_vb_prev = 1'b0;

    always #20 clk = ~clk;

    vga_frame_reader u_a (
        .clk(clk), .rst_n(rst_n), .addr_out(a_addr), .regread(a_rr), .data_out(a_data),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vblank(a_vb), .frame_end(a_fe)
    );

    vga_frame_reader #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_b (
        .clk(clk), .rst_n(rst_n), .addr_out(b_addr), .regread(b_rr), .data_out(b_data),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vblank(b_vb), .frame_end(b_fe)
    );

    // Dual-port RAM read side: one-cycle registered read.
    always @(posedge clk) begin
        if (a_rr) a_data <= mem[a_addr];
        if (b_rr) b_data <= mem[b_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic m_active(input int i, input int vact, input int vtot);
        int hh = i % 800;
        int vv = (i / 800) % vtot;
        return (hh < 640) && (vv < vact);
    endfunction

    function automatic int m_addr(input int i, input int vtot);
        int hh = i % 800;
        int vv = (i / 800) % vtot;
        return (vv / 2) * 320 + hh / 2;
    endfunction

    // Expected outputs after edge k: stage 1 reflects counter index k-1, pins index k-3.
    task automatic cmp_cycle(input int sel, input int vact, input int vfp, input int vsy, input int vtot,
                             input logic [16:0] addr, input logic rr, input logic hs, input logic vs,
                             input logic [15:0] rgb, input logic vb, input logic fe);
        int i1 = k - 1;
        int i3 = k - 3;
        int hh, vv;
        logic e_rr, e_hs, e_vs, e_vb, e_fe;
        logic [15:0] e_rgb;
        e_rr = 1'b0;
        if (k >= 1 && m_active(i1, vact, vtot)) begin
            last_addr[sel] = m_addr(i1, vtot);
            e_rr = 1'b1;
        end
        e_rgb = 16'h0; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_fe = 1'b0;
        if (k >= 3) begin
            hh = i3 % 800;
            vv = (i3 / 800) % vtot;
            if (m_active(i3, vact, vtot)) e_rgb = mem[m_addr(i3, vtot)];
            e_hs = !(hh >= 656 && hh <= 751);
            e_vs = !(vv >= vact + vfp && vv < vact + vfp + vsy);
            e_vb = (vv >= vact);
            e_fe = (hh == 0) && (vv == vact);
        end
        if (addr !== 17'(last_addr[sel])) err[sel][0]++;
        if (rr !== e_rr)   err[sel][1]++;
        if (rgb !== e_rgb) err[sel][2]++;
        if (hs !== e_hs)   err[sel][3]++;
        if (vs !== e_vs)   err[sel][4]++;
        if (vb !== e_vb)   err[sel][5]++;
        if (fe !== e_fe)   err[sel][6]++;
    endtask

    task automatic directed();
        if (phase == 1) begin
            if (k == 1)    begin check_val("addr_k1", a_addr, 0); check_val("rr_k1", a_rr, 1); end
            if (k == 2)    begin check_val("addr_k2", a_addr, 0); check_val("rgb_k2", {a_r, a_g, a_b}, 0); end
            if (k == 3)    begin check_val("r_px0", a_r, 31); check_val("g_px0", a_g, 0); end
            if (k == 4)    check_val("r_px1", a_r, 31);
            if (k == 5)    begin check_val("g_px2", a_g, 63); check_val("r_px2", a_r, 0); end
            if (k == 6)    check_val("g_px3", a_g, 63);
            if (k == 7)    check_val("b_px4", a_b, 31);
            if (k == 8)    check_val("b_px5", a_b, 31);
            if (k == 640)  check_val("addr_h639", a_addr, 319);
            if (k == 641)  begin check_val("rr_fall", a_rr, 0); check_val("addr_hold", a_addr, 319); end
            if (k == 800)  check_val("rr_blank_end", a_rr, 0);
            if (k == 801)  begin check_val("addr_v1", a_addr, 0); check_val("rr_rise", a_rr, 1); end
            if (k == 1601) check_val("addr_v2", a_addr, 320);
            if (k >= 3 && k <= 802) begin
                if (!a_hs) begin
                    if (hs_low == 0) hs_first = k;
                    hs_low++;
                end
            end
            if (k >= 3 && k <= 9602 && !b_vs) vs_low++;
            if (b_rr && int'(b_addr) > b_max) b_max = int'(b_addr);
            if (b_fe) begin
                fe_cnt++;
                if (fe_cnt == 1) fe_k1 = k;
                if (fe_cnt == 2) fe_k2 = k;
                check_val("fe_vblank_high", b_vb, 1);
                check_val("fe_vblank_prev", b_vb_prev, 0);
            end
            b_vb_prev = b_vb;
        end else if (phase == 2) begin
            if (k == 1) begin check_val("rst_stale_rgb1", {a_r, a_g, a_b}, 0); check_val("rst_addr_k1", a_addr, 0); end
            if (k == 2) check_val("rst_stale_rgb2", {a_r, a_g, a_b}, 0);
            if (k == 3) check_val("rst_r_px0", a_r, 31);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            cmp_cycle(0, 480, 10, 2, 525, a_addr, a_rr, a_hs, a_vs, {a_r, a_g, a_b}, a_vb, a_fe);
            cmp_cycle(1, 6, 2, 2, 12, b_addr, b_rr, b_hs, b_vs, {b_r, b_g, b_b}, b_vb, b_fe);
            directed();
        end
    endtask

    task automatic check_aggregates(input string pfx);
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 7; j++) begin
                check_val($sformatf("%s_%s_%s", pfx, (s == 0) ? "a" : "b", sig_names[j]), err[s][j], 0);
                err[s][j] = 0;
            end
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_addr"},  a_addr, 0);
        check_val({pfx, "_rr"},    a_rr, 0);
        check_val({pfx, "_hs"},    a_hs, 1);
        check_val({pfx, "_vs"},    a_vs, 1);
        check_val({pfx, "_rgb"},   {a_r, a_g, a_b}, 0);
        check_val({pfx, "_vb"},    a_vb, 0);
        check_val({pfx, "_fe"},    a_fe, 0);
        check_val({pfx, "_b_addr"}, b_addr, 0);
        check_val({pfx, "_b_rgb"}, {b_r, b_g, b_b}, 0);
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'hF800;
        mem[1] = 16'h07E0;
        mem[2] = 16'h001F;
        for (int s = 0; s < 2; s++) begin
            last_addr[s] = 0;
            for (int j = 0; j < 7; j++) err[s][j] = 0;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");

        rst_n = 1'b1;
        k = 0;
        phase = 1;
        run_cycles(19500);
        check_aggregates("scan");
        check_val("hs_first_low", hs_first, 659);
        check_val("hs_low_len", hs_low, 96);
        check_val("vs_low_len", vs_low, 1600);
        check_val("fe_count", fe_cnt, 2);
        check_val("fe_first", fe_k1, 4803);
        check_val("fe_period", fe_k2 - fe_k1, 9600);
        check_val("b_max_addr", b_max, 959);

        // Counter now sits at h=300 of an active line; reset must clear at once.
        phase = 0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        last_addr[0] = 0;
        last_addr[1] = 0;
        phase = 2;
        run_cycles(2500);
        check_aggregates("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
